// File: rtl/hls_deadlock_report_ctrl_pkg.sv
// Shared types and helpers for the deadlock report controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hls_deadlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WATCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int AXIS_W_DEF    = 6;
    localparam int IDLE_W_DEF    = 4;
    localparam int HOLDOFF_QUIET = 2;

    // Increment v, but never past the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/hls_deadlock_report_ctrl_if.sv
// Bundle of config, monitor inputs and status outputs of the report controller.
// Latency: n/a (wiring only).
// Backpressure: none; ack is a single-cycle pulse from software.
interface hls_deadlock_report_ctrl_if
    import hls_deadlock_pkg::*;
#(
    parameter int AXIS_W = AXIS_W_DEF,
    parameter int IDLE_W = IDLE_W_DEF,
    parameter int CNT_W  = 16,
    parameter int EVT_W  = 8
);
    logic              enable;
    logic [CNT_W-1:0]  threshold;
    logic              block_in;
    logic [AXIS_W-1:0] axis_block_sigs;
    logic [IDLE_W-1:0] inst_idle_sigs;
    logic              ack;
    logic              irq;
    logic [AXIS_W-1:0] snap_axis;
    logic [IDLE_W-1:0] snap_idle;
    logic [CNT_W-1:0]  snap_stall;
    logic [EVT_W-1:0]  event_count;
    logic [2:0]        state_o;

    modport master (
        output enable, threshold, block_in, axis_block_sigs, inst_idle_sigs, ack,
        input  irq, snap_axis, snap_idle, snap_stall, event_count, state_o
    );

    modport slave (
        input  enable, threshold, block_in, axis_block_sigs, inst_idle_sigs, ack,
        output irq, snap_axis, snap_idle, snap_stall, event_count, state_o
    );
endinterface

// File: rtl/hls_deadlock_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: 1 cycle from clr/en to updated count.
// Backpressure: none; holds at all-ones instead of wrapping.
module hls_deadlock_sat_counter
    import hls_deadlock_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    // Count register: clear has priority, otherwise step and saturate.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= W'(sat_inc(32'(r_cnt), W));
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// Filters persistent block stalls, snapshots offending channels, raises a level IRQ until ack.
// Latency: irq rises 2 clocks after the threshold-th consecutive block cycle; all outputs registered.
// Backpressure: none; a pending report is held in REPORT until software acks, further stalls wait.
module hls_deadlock_report_ctrl
    import hls_deadlock_pkg::*;
#(
    parameter int AXIS_W = AXIS_W_DEF,
    parameter int IDLE_W = IDLE_W_DEF,
    parameter int CNT_W  = 16,
    parameter int EVT_W  = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    hls_deadlock_report_ctrl_if.slave   bus
);
    localparam int QUIET_W = 2;

    state_t             r_state;
    state_t             w_next;
    logic               r_irq;
    logic [AXIS_W-1:0]  r_snap_axis;
    logic [IDLE_W-1:0]  r_snap_idle;
    logic [CNT_W-1:0]   r_snap_stall;

    logic [CNT_W-1:0]   w_stall_cnt;
    logic [CNT_W-1:0]   w_stall_inc;
    logic [CNT_W-1:0]   w_eff_th;
    logic [QUIET_W-1:0] w_quiet_cnt;
    logic [QUIET_W-1:0] w_quiet_inc;
    logic [EVT_W-1:0]   w_evt_cnt;

    // A zero threshold would otherwise declare deadlock with no block cycle at all.
    assign w_eff_th    = (bus.threshold == '0) ? CNT_W'(1) : bus.threshold;
    assign w_stall_inc = CNT_W'(sat_inc(32'(w_stall_cnt), CNT_W));
    assign w_quiet_inc = QUIET_W'(sat_inc(32'(w_quiet_cnt), QUIET_W));

    // Stall length only accumulates while watching; any gap or disable restarts it.
    hls_deadlock_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   ((r_state != ST_WATCH) || !bus.block_in || !bus.enable),
        .i_en    (bus.block_in),
        .o_cnt   (w_stall_cnt)
    );

    // Consecutive quiet cycles after an ack, used to re-arm only once the stall is gone.
    hls_deadlock_sat_counter #(.W(QUIET_W)) u_quiet_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   ((r_state != ST_HOLDOFF) || bus.block_in),
        .i_en    (1'b1),
        .o_cnt   (w_quiet_cnt)
    );

    // One count per reported deadlock, sticky at all-ones.
    hls_deadlock_sat_counter #(.W(EVT_W)) u_evt_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (1'b0),
        .i_en    (r_state == ST_CAPTURE),
        .o_cnt   (w_evt_cnt)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; CAPTURE ignores enable, REPORT only leaves on ack.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.enable) w_next = ST_WATCH;
            end
            ST_WATCH: begin
                if (!bus.enable)                                    w_next = ST_IDLE;
                else if (bus.block_in && (w_stall_inc >= w_eff_th)) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.ack) w_next = bus.enable ? ST_HOLDOFF : ST_IDLE;
            end
            ST_HOLDOFF: begin
                if (!bus.enable) w_next = ST_IDLE;
                else if (!bus.block_in && (32'(w_quiet_inc) >= 32'(HOLDOFF_QUIET)))
                    w_next = ST_WATCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Registered irq and snapshot capture; stall counter already holds the incremented length here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq        <= 1'b0;
            r_snap_axis  <= '0;
            r_snap_idle  <= '0;
            r_snap_stall <= '0;
        end else begin
            r_irq <= (w_next == ST_REPORT);
            if (r_state == ST_CAPTURE) begin
                r_snap_axis  <= bus.axis_block_sigs;
                r_snap_idle  <= bus.inst_idle_sigs;
                r_snap_stall <= w_stall_cnt;
            end
        end
    end

    assign bus.irq         = r_irq;
    assign bus.snap_axis   = r_snap_axis;
    assign bus.snap_idle   = r_snap_idle;
    assign bus.snap_stall  = r_snap_stall;
    assign bus.event_count = w_evt_cnt;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_hls_deadlock_report_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    hls_deadlock_report_ctrl_if #(.AXIS_W(6), .IDLE_W(4), .CNT_W(16), .EVT_W(8)) bus ();

    hls_deadlock_report_ctrl #(.AXIS_W(6), .IDLE_W(4), .CNT_W(16), .EVT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every input active.
        reset_n             = 1'b0;
        bus.enable          = 1'b1;
        bus.threshold       = 16'd1;
        bus.block_in        = 1'b1;
        bus.axis_block_sigs = 6'h3F;
        bus.inst_idle_sigs  = 4'hF;
        bus.ack             = 1'b1;
        #12;
        check("rst_irq",   32'(bus.irq), 0);
        check("rst_saxis", 32'(bus.snap_axis), 0);
        check("rst_sidle", 32'(bus.snap_idle), 0);
        check("rst_sstall",32'(bus.snap_stall), 0);
        check("rst_evt",   32'(bus.event_count), 0);
        check("rst_state", 32'(bus.state_o), 0);

        bus.block_in        = 1'b0;
        bus.ack             = 1'b0;
        bus.threshold       = 16'd4;
        bus.axis_block_sigs = 6'b000000;
        bus.inst_idle_sigs  = 4'b0000;
        #5 reset_n = 1'b1;
        tick();
        check("idle_to_watch", 32'(bus.state_o), 1);

        // First burst of 3 block cycles must not trigger.
        bus.block_in = 1'b1;
        repeat (3) tick();
        bus.block_in = 1'b0;
        tick();
        check("burst3_state", 32'(bus.state_o), 1);
        check("burst3_irq",   32'(bus.irq), 0);

        // Second burst of 4 block cycles with a known channel pattern.
        bus.block_in        = 1'b1;
        bus.axis_block_sigs = 6'b000101;
        bus.inst_idle_sigs  = 4'b0010;
        repeat (3) tick();
        check("burst4_pre_state", 32'(bus.state_o), 1);
        tick();
        check("capture_state", 32'(bus.state_o), 2);
        check("capture_irq",   32'(bus.irq), 0);
        tick();
        check("report_state", 32'(bus.state_o), 3);
        check("report_irq",   32'(bus.irq), 1);
        check("snap_axis",    32'(bus.snap_axis), 32'h05);
        check("snap_idle",    32'(bus.snap_idle), 32'h2);
        check("snap_stall",   32'(bus.snap_stall), 4);
        check("evt_1",        32'(bus.event_count), 1);

        // Snapshots must not follow live inputs after capture.
        bus.axis_block_sigs = 6'b111000;
        bus.inst_idle_sigs  = 4'b1100;
        tick();
        check("snap_hold_axis", 32'(bus.snap_axis), 32'h05);
        check("report_stays",   32'(bus.irq), 1);

        // Ack with the stall still present: holdoff until 2 quiet cycles.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("ack_irq",   32'(bus.irq), 0);
        check("ack_state", 32'(bus.state_o), 4);
        repeat (3) tick();
        check("holdoff_blocked", 32'(bus.state_o), 4);
        bus.block_in = 1'b0;
        tick();
        check("holdoff_quiet1", 32'(bus.state_o), 4);
        tick();
        check("holdoff_rearm", 32'(bus.state_o), 1);
        repeat (2) tick();
        check("no_rereport",   32'(bus.irq), 0);
        check("snap_after_ack",32'(bus.snap_idle), 32'h2);

        // threshold = 0 behaves as 1.
        bus.threshold = 16'd0;
        bus.block_in  = 1'b1;
        tick();
        check("th0_capture", 32'(bus.state_o), 2);
        tick();
        check("th0_irq",   32'(bus.irq), 1);
        check("th0_stall", 32'(bus.snap_stall), 1);
        check("th0_evt",   32'(bus.event_count), 2);

        // 300 more deadlock/ack rounds: event count sticks at 255.
        for (int i = 0; i < 300; i++) begin
            bus.ack      = 1'b1;
            bus.block_in = 1'b0;
            tick();
            bus.ack = 1'b0;
            repeat (2) tick();
            bus.block_in = 1'b1;
            repeat (2) tick();
        end
        check("sat_evt",   32'(bus.event_count), 255);
        check("sat_state", 32'(bus.state_o), 3);

        // Disable while reporting keeps irq; ack with enable low goes idle.
        bus.block_in = 1'b0;
        bus.enable   = 1'b0;
        tick();
        check("dis_irq",   32'(bus.irq), 1);
        check("dis_state", 32'(bus.state_o), 3);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("dis_ack_state", 32'(bus.state_o), 0);
        check("dis_ack_irq",   32'(bus.irq), 0);

        // New report, then asynchronous reset mid-cycle.
        bus.enable          = 1'b1;
        bus.threshold       = 16'd1;
        bus.block_in        = 1'b1;
        bus.axis_block_sigs = 6'b110011;
        bus.inst_idle_sigs  = 4'b1001;
        repeat (3) tick();
        check("pre_arst_irq",  32'(bus.irq), 1);
        check("pre_arst_axis", 32'(bus.snap_axis), 32'h33);
        #2 reset_n = 1'b0;
        #1;
        check("arst_irq",   32'(bus.irq), 0);
        check("arst_axis",  32'(bus.snap_axis), 0);
        check("arst_idle",  32'(bus.snap_idle), 0);
        check("arst_stall", 32'(bus.snap_stall), 0);
        check("arst_evt",   32'(bus.event_count), 0);
        check("arst_state", 32'(bus.state_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hls_deadlock_report_ctrl.md
Name: hls_deadlock_report_ctrl

Overview:
- Controller that sequences deadlock reporting for the HLS SNN core.
- Consumes the top-level deadlock monitor's `block` output plus the raw AXIS block and instance idle vectors.
- Filters transient stalls with a programmable persistence threshold, captures a snapshot of the offending channels, and raises an interrupt held until software acknowledges it.
- Sits between the monitor tree and the AXI-Lite status/IRQ wrapper.

Parameters:
- AXIS_W, 6, width of axis_block_sigs.
- IDLE_W, 4, width of inst_idle_sigs.
- CNT_W, 16, width of threshold and stall counters.
- EVT_W, 8, width of event counter.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  reporting enable (config register bit).
- threshold  in  CNT_W  consecutive block cycles required to declare deadlock; 0 is treated as 1.
- block_in  in  1  registered block flag from the deadlock monitor.
- axis_block_sigs  in  AXIS_W  per-channel AXIS block flags.
- inst_idle_sigs  in  IDLE_W  per-instance idle flags.
- ack  in  1  single-cycle interrupt acknowledge from software.
- irq  out  1  deadlock interrupt, level.
- snap_axis  out  AXIS_W  axis_block_sigs captured at detection.
- snap_idle  out  IDLE_W  inst_idle_sigs captured at detection.
- snap_stall  out  CNT_W  stall length in cycles at detection.
- event_count  out  EVT_W  number of deadlocks reported, saturating.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset (async on reset_n low, released synchronously by the reset tree):
  - state = IDLE; irq = 0.
  - snap_axis, snap_idle, snap_stall, event_count = 0.
  - Stall counter = 0; quiet counter = 0.
- States and encoding: IDLE=0, WATCH=1, CAPTURE=2, REPORT=3, HOLDOFF=4.
- IDLE:
  - Stall counter held at 0.
  - enable=1 moves to WATCH next cycle.
- WATCH:
  - block_in=1 increments the stall counter, saturating at all-ones.
  - block_in=0 clears the counter and stays in WATCH.
  - Let eff_th = max(threshold, 1). When block_in=1 and counter+1 >= eff_th, go to CAPTURE. With threshold=1 this happens on the first block cycle.
  - enable=0 returns to IDLE and clears the counter.
  - threshold is sampled every cycle; lowering it mid-count can trigger immediately.
- CAPTURE (exactly 1 cycle):
  - Latch snap_axis and snap_idle from the current inputs.
  - snap_stall = counter+1, saturating.
  - event_count increments, saturating at 2^EVT_W-1.
  - Go to REPORT unconditionally; enable is ignored in this cycle.
- REPORT:
  - irq=1, registered, so the first irq-high cycle is the cycle after CAPTURE. Latency from the threshold-th block cycle to irq=1 is 2 clocks.
  - ack=1 goes to HOLDOFF, with irq=0 from the next cycle.
  - enable=0 does not drop irq; a pending report survives until acknowledged.
  - ack=1 together with enable=0 goes to IDLE.
  - ack outside REPORT is ignored.
- HOLDOFF:
  - Prevents re-reporting the same stall.
  - The quiet counter counts consecutive block_in=0 cycles; block_in=1 clears it.
  - Two consecutive quiet cycles go to WATCH with the stall counter cleared.
  - enable=0 goes to IDLE.
- Snapshot registers hold their values until the next CAPTURE; they are not cleared by ack or by enable.
- Outputs change only on clock edges or on async reset; there is no combinational path from inputs to outputs.
- Reset asserted mid-REPORT drops irq immediately (asynchronously) and clears all snapshots.

Decomposition:
- Shared package `hls_deadlock_pkg` holds:
  - the state enum (IDLE..HOLDOFF, 3-bit);
  - localparams AXIS_W_DEF=6, IDLE_W_DEF=4, HOLDOFF_QUIET=2;
  - the saturating-increment function.
- One natural sub-module, `hls_deadlock_sat_counter`: parameterised-width saturating counter with clear and enable inputs. It is instantiated for the stall counter, quiet counter and event counter.
- The FSM and snapshot registers remain in the top.

Test Plan:
- Reset with all inputs active → irq=0, snapshots=0, event_count=0, state_o=0; after release with enable=1, state_o=1 on the next cycle.
- threshold=4, block_in high 3 cycles then low, then high 4 cycles with axis_block_sigs=6'b000101, inst_idle_sigs=4'b0010:
  - no irq after the first burst;
  - irq rises 2 clocks after the 4th block cycle of the second burst;
  - snap_axis=6'b000101, snap_idle=4'b0010, snap_stall=4, event_count=1.
- In REPORT, hold block_in=1 and pulse ack:
  - irq falls next cycle and the FSM stays in HOLDOFF while block_in=1;
  - after block_in=0 for 2 cycles, state_o=1;
  - no second irq from the original stall.
- threshold=0 → irq after a single block_in cycle with snap_stall=1. Drive 300 deadlock/ack sequences → event_count saturates at 255.
- In REPORT, drop enable → irq stays 1. Then ack=1 with enable=0 → state_o=0 and irq=0.
- Assert reset_n low asynchronously, mid-cycle, during REPORT → irq and all snapshots go to 0 before the next clock edge.
